led_morse_scheduler: RTL
========================

# led_morse_scheduler

Shares the board's single status LED between two independent message sources and sequences it with Morse timing. Each requester streams symbols (dot, dash, letter gap, word gap) over a valid/ready handshake. The block grants the LED to one requester for a whole message, round-robin between messages, and drives `led` with exact unit-based on/off durations. It sits between the pattern generators (SOS, fault codes) and the LED pin on the 50 MHz board clock.

## Interface
- `UNIT_CYCLES`, default 5_000_000: clock cycles per Morse time unit (100 ms at 50 MHz); legal range 1..2^24-1.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 symbol valid.
- `req0_sym`  in  2  requester 0 symbol: 0 dot, 1 dash, 2 letter gap, 3 word gap.
- `req0_last`  in  1  symbol is the final one of requester 0's message.
- `req0_ready`  out  1  requester 0 symbol accepted this cycle when valid.
- `req1_valid`, `req1_sym`, `req1_last`, `req1_ready`: same as above, for requester 1.
- `led`  out  1  LED drive, 1 = on.
- `busy`  out  1  symbol playing or message lock held.
- `owner`  out  1  index of the requester currently granted; valid only while `busy`.

## Operation
- FSM states: IDLE, ON, OFF.
- IDLE:
  - Selects the requester.
  - If lock held: the locked requester only.
  - Else: among valid requesters, priority to `rr_ptr`, otherwise the other.
  - The selected requester's ready = 1. All other readies are always 0.
- Acceptance (valid & ready in IDLE):
  - Latch symbol; set `owner`; set lock.
  - Record whether the symbol is `last`.
  - Load `units_left`:
    - dot: ON 1 unit.
    - dash: ON 3 units.
    - letter gap: OFF 2 units.
    - word gap: OFF 6 units.
  - Dot/dash go to ON; gaps go directly to OFF.
- ON:
  - `led` = 1.
  - On final unit tick, go to OFF with 1 intra-symbol unit.
- OFF:
  - `led` = 0.
  - On final unit tick, go to IDLE.
  - If the symbol was `last`: clear lock and set `rr_ptr` = other requester.
- Lock persists while the locked requester has `valid` low. The sequencer idles and does not grant the other requester.
- Unit timer: `unit_cnt` counts 0..UNIT_CYCLES-1 while in ON/OFF, and is cleared on every state entry. A tick occurs when `unit_cnt` == UNIT_CYCLES-1.
- `units_left` decrements on each tick; it is 3 bits wide.
- `busy` = (state != IDLE) | lock.

## Timing
- Reset values: `led` 0, `req0_ready`/`req1_ready` 0, `busy` 0, `owner` 0, state IDLE, lock 0, `rr_ptr` 0.
- Asserting `rst` mid-symbol forces `led` low immediately and discards the message.
- Readies are combinational from state/lock/valid/`rr_ptr`.
- Ready is never asserted outside IDLE.
- `led` is registered. It rises the cycle after acceptance and stays high for exactly N×UNIT_CYCLES cycles.
- OFF lasts exactly M×UNIT_CYCLES cycles, followed by 1 IDLE cycle. Per-symbol period = (N+M)×UNIT_CYCLES + 1 cycles.
- Symbol totals:
  - dot: N=1, M=1.
  - dash: N=3, M=1.
  - letter gap: N=0, M=2.
  - word gap: N=0, M=6.
- Both requesters valid in an unlocked IDLE: `rr_ptr` wins, with no bubble.
- UNIT_CYCLES=1: ticks every cycle; durations above still hold exactly.

## Structure
- Package `morse_pkg`:
  - Symbol enum (DOT, DASH, LGAP, WGAP).
  - FSM state enum.
  - Unit-count constants: DOT_UNITS=1, DASH_UNITS=3, INTRA_UNITS=1, LGAP_UNITS=2, WGAP_UNITS=6.
- One sub-module, `morse_unit_timer`:
  - Parameter UNIT_CYCLES.
  - Inputs: `clk`, `rst`, `clear`, `run`.
  - Output: `tick`.
- Arbitration, lock and FSM live in the top module.

## Test plan
All directed scenarios use UNIT_CYCLES=4.
- **Reset:** hold `rst` 3 cycles with both valids high → `led`/readies/`busy` 0 throughout; `req0_ready`=1 the first cycle after release.
- **Dot:** req0 dot, last=1, accepted at cycle T → `led`=1 for T+1..T+4, 0 for T+5..T+8; IDLE at T+9; `busy` 0 at T+9.
- **Dash, then word gap:** req1, two symbols → `led` high 12 cycles, low 4, one IDLE cycle, then low 24 cycles; `owner`=1 throughout.
- **Arbitration:**
  - Stimulus: both valid after reset; req0 sends a 2-symbol message (dot, dot-last).
  - Response: `req1_ready` stays 0 until req0's message completes; req1 is granted next.
  - Then req0 is granted again only after req1's last symbol (round-robin).
- **Lock stall:** req0 drops valid for 20 cycles mid-message while req1 is valid → `busy`=1, `led`=0, no grant to req1; req0 resumes and finishes first.
- **Reset mid-dash:** assert `rst` 6 cycles into ON → `led` low in the same cycle; after release, a req1-only request is granted immediately and plays normally.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and unit-count constants for the Morse LED scheduler.
package morse_pkg;

    typedef enum logic [1:0] {
        DOT  = 2'd0,
        DASH = 2'd1,
        LGAP = 2'd2,
        WGAP = 2'd3
    } sym_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    localparam logic [2:0] DOT_UNITS   = 3'd1;
    localparam logic [2:0] DASH_UNITS  = 3'd3;
    localparam logic [2:0] INTRA_UNITS = 3'd1;
    localparam logic [2:0] LGAP_UNITS  = 3'd2;
    localparam logic [2:0] WGAP_UNITS  = 3'd6;

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running Morse unit timer: counts 0..UNIT_CYCLES-1 while run is high and
// pulses tick on the last count of each unit.
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    logic [23:0] unit_cnt;

    assign tick = run && (unit_cnt == 24'(UNIT_CYCLES - 1));

    // Unit counter; wraps on tick so consecutive units stay back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_cnt <= 24'd0;
        end else if (clear) begin
            unit_cnt <= 24'd0;
        end else if (run) begin
            unit_cnt <= tick ? 24'd0 : unit_cnt + 24'd1;
        end else begin
            unit_cnt <= unit_cnt;
        end
    end

endmodule

// File: rtl/led_morse_scheduler.sv
// Arbitrates the status LED between two Morse symbol streams, granting a whole
// message at a time round-robin, and plays each symbol with exact unit timing.
module led_morse_scheduler
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_sym,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_sym,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       led,
    output logic       busy,
    output logic       owner
);

    state_t     state, state_next;
    logic       lock, lock_next;
    logic       owner_next;
    logic       rr_ptr, rr_next;
    logic       is_last, last_next;
    logic [2:0] units_left, units_next;
    logic       sel, grant, accept, tick;
    logic [1:0] valid;
    sym_t       sel_sym;

    assign valid   = {req1_valid, req0_valid};
    assign sel_sym = sym_t'(sel ? req1_sym : req0_sym);

    // Requester selection: the lock holder only, else rr_ptr first.
    always_comb begin
        sel   = rr_ptr;
        grant = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (lock) begin
                sel   = owner;
                grant = 1'b1;
            end else if (valid[rr_ptr]) begin
                sel   = rr_ptr;
                grant = 1'b1;
            end else if (valid[~rr_ptr]) begin
                sel   = ~rr_ptr;
                grant = 1'b1;
            end else begin
                grant = 1'b0;
            end
        end else begin
            grant = 1'b0;
        end
    end

    assign req0_ready = grant && (sel == 1'b0);
    assign req1_ready = grant && (sel == 1'b1);
    assign accept     = grant && valid[sel];

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_next != state),
        .run   (state != S_IDLE),
        .tick  (tick)
    );

    // Next-state, lock and round-robin bookkeeping.
    always_comb begin
        state_next = state;
        lock_next  = lock;
        owner_next = owner;
        rr_next    = rr_ptr;
        last_next  = is_last;
        units_next = units_left;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    owner_next = sel;
                    lock_next  = 1'b1;
                    last_next  = sel ? req1_last : req0_last;
                    case (sel_sym)
                        DOT:     begin units_next = DOT_UNITS;  state_next = S_ON;  end
                        DASH:    begin units_next = DASH_UNITS; state_next = S_ON;  end
                        LGAP:    begin units_next = LGAP_UNITS; state_next = S_OFF; end
                        WGAP:    begin units_next = WGAP_UNITS; state_next = S_OFF; end
                        default: begin units_next = DOT_UNITS;  state_next = S_ON;  end
                    endcase
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ON: begin
                if (tick && units_left == 3'd1) begin
                    state_next = S_OFF;
                    units_next = INTRA_UNITS;
                end else if (tick) begin
                    units_next = units_left - 3'd1;
                end else begin
                    units_next = units_left;
                end
            end
            S_OFF: begin
                if (tick && units_left == 3'd1) begin
                    state_next = S_IDLE;
                    if (is_last) begin
                        lock_next = 1'b0;
                        rr_next   = ~owner;
                    end else begin
                        lock_next = lock;
                    end
                end else if (tick) begin
                    units_next = units_left - 3'd1;
                end else begin
                    units_next = units_left;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; led follows the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lock       <= 1'b0;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            is_last    <= 1'b0;
            units_left <= 3'd0;
            led        <= 1'b0;
        end else begin
            state      <= state_next;
            lock       <= lock_next;
            owner      <= owner_next;
            rr_ptr     <= rr_next;
            is_last    <= last_next;
            units_left <= units_next;
            led        <= (state_next == S_ON);
        end
    end

    assign busy = (state != S_IDLE) || lock;

endmodule
